// File: rtl/lift_row_sequencer.sv
// Row sequencer for the parallel lifting datapath: RAM read, operand load, fire, result write.
// Optional WACK timeout enabled by defining LIFT_SEQ_TIMEOUT_EN.
module lift_row_sequencer #(
   parameter int DW  = 144,
   parameter int AW  = 10,
   parameter int FW  = 80,
   parameter int RW  = 9,
   parameter int TMO = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [AW-1:0] num_rows,
   input  logic [FW-1:0] flgs_cfg,
   output logic [AW-1:0] addr_coef,
   output logic          we_coef,
   input  logic [DW-1:0] dout_lf,
   input  logic [DW-1:0] dout_sa,
   input  logic [DW-1:0] dout_rt,
   output logic [DW-1:0] left_s_i,
   output logic [DW-1:0] sam_s_i,
   output logic [DW-1:0] right_s_i,
   output logic [FW-1:0] flgs_s_i,
   output logic [AW-1:0] row_ind,
   output logic          update_s,
   input  logic          res_valid,
   input  logic [AW-1:0] res_out_x,
   output logic [AW-1:0] addr_res,
   output logic [RW-1:0] din_res,
   output logic          we_res,
   output logic          busy,
   output logic          done,
   output logic          err
);

   typedef enum logic [3:0] {
      IDLE, RD, LAT, LOAD, FIRE, WACK, WR, NEXT, FIN
   } state_t;

   state_t        state, nxt;
   logic [AW-1:0] row, nrows;
   logic [FW-1:0] flgs_q;
   logic [RW-1:0] res_q;
   logic          last;
   logic          tmo_hit;
   logic          unused_ok;

   assign last      = (row == nrows - AW'(1));
   assign unused_ok = ^res_out_x[AW-1:RW];

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt = state;
      unique case (state)
         IDLE: if (start) nxt = (num_rows == '0) ? FIN : RD;
         RD:   nxt = LAT;
         LAT:  nxt = LOAD;
         LOAD: nxt = FIRE;
         FIRE: nxt = WACK;
         WACK: begin
            if (res_valid)    nxt = WR;
            else if (tmo_hit) nxt = NEXT;
         end
         WR:   nxt = NEXT;
         NEXT: nxt = last ? FIN : RD;
         FIN:  nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // a write is dropped if reset lands on the WR cycle
   always_comb begin
      busy     = (state != IDLE);
      update_s = (state == FIRE);
      we_res   = (state == WR) && !rst;
   end

   assign we_coef   = 1'b0;
   assign addr_coef = row;
   assign addr_res  = row;
   assign din_res   = res_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         row       <= '0;
         nrows     <= '0;
         flgs_q    <= '0;
         res_q     <= '0;
         left_s_i  <= '0;
         sam_s_i   <= '0;
         right_s_i <= '0;
         flgs_s_i  <= '0;
         row_ind   <= '0;
         done      <= 1'b0;
      end else begin
         done <= (state == FIN);
         unique case (state)
            IDLE: if (start) begin
               nrows  <= num_rows;
               flgs_q <= flgs_cfg;
               row    <= '0;
            end
            LOAD: begin
               left_s_i  <= dout_lf;
               sam_s_i   <= dout_sa;
               right_s_i <= dout_rt;
               flgs_s_i  <= flgs_q;
               row_ind   <= row;
            end
            WACK: if (res_valid) res_q <= res_out_x[RW-1:0];
            NEXT: if (!last) row <= row + AW'(1);
            default: ;
         endcase
      end
   end

`ifdef LIFT_SEQ_TIMEOUT_EN
   localparam int CW = $clog2(TMO + 1);
   logic [CW-1:0] wcnt;
   logic          err_q;

   assign tmo_hit = (state == WACK) && !res_valid
                    && (wcnt == CW'(TMO - 1));
   assign err     = err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         wcnt  <= '0;
         err_q <= 1'b0;
      end else begin
         wcnt <= (state == WACK) ? wcnt + CW'(1) : '0;
         if (state == IDLE && start) err_q <= 1'b0;
         else if (tmo_hit)           err_q <= 1'b1;
      end
   end
`else
   assign tmo_hit = 1'b0;
   assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_lift_row_sequencer.sv
// Scoreboard bench for lift_row_sequencer: RAM and lifting-core models, write queue.
// Timeout expectations follow LIFT_SEQ_TIMEOUT_EN.
module tb_lift_row_sequencer;

   localparam int DW = 144;
   localparam int AW = 10;
   localparam int FW = 80;
   localparam int RW = 9;

   typedef struct {
      logic [AW-1:0] a;
      logic [RW-1:0] d;
   } wr_t;

   logic          clk = 1'b0;
   logic          rst, start;
   logic [AW-1:0] num_rows;
   logic [FW-1:0] flgs_cfg;
   logic [AW-1:0] addr_coef, row_ind, addr_res, res_out_x;
   logic          we_coef, update_s, res_valid, we_res;
   logic          busy, done, err;
   logic [DW-1:0] dout_lf, dout_sa, dout_rt;
   logic [DW-1:0] left_s_i, sam_s_i, right_s_i;
   logic [FW-1:0] flgs_s_i;
   logic [RW-1:0] din_res;
   logic          core_rv, spur_rv;

   logic [DW-1:0] mem_lf [1024];
   logic [DW-1:0] mem_sa [1024];
   logic [DW-1:0] mem_rt [1024];

   wr_t sb[$];
   int  upd_q[$];
   int  vectors = 0, miscompares = 0;
   int  cyc = 0, rv_cyc = 0;
   int  upd_cnt = 0, done_cnt = 0;
   int  core_delay = 1, skip_row = -1;
   bit  use_fixed = 0;
   logic [AW-1:0] fixed_res = '0;

   assign res_valid = core_rv | spur_rv;

   lift_row_sequencer dut (
      .clk(clk), .rst(rst), .start(start),
      .num_rows(num_rows), .flgs_cfg(flgs_cfg),
      .addr_coef(addr_coef), .we_coef(we_coef),
      .dout_lf(dout_lf), .dout_sa(dout_sa), .dout_rt(dout_rt),
      .left_s_i(left_s_i), .sam_s_i(sam_s_i),
      .right_s_i(right_s_i), .flgs_s_i(flgs_s_i),
      .row_ind(row_ind), .update_s(update_s),
      .res_valid(res_valid), .res_out_x(res_out_x),
      .addr_res(addr_res), .din_res(din_res), .we_res(we_res),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      dout_lf <= mem_lf[addr_coef];
      dout_sa <= mem_sa[addr_coef];
      dout_rt <= mem_rt[addr_coef];
   end

   task automatic check(input string tag,
                        input logic [159:0] got,
                        input logic [159:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // lifting core: answers core_delay cycles after update_s
   initial begin
      logic [AW-1:0] r;
      core_rv   = 1'b0;
      res_out_x = 10'h155;
      forever begin
         @(posedge clk);
         if (update_s === 1'b1) begin
            r = row_ind;
            if (int'(r) != skip_row) begin
               repeat (core_delay - 1) @(posedge clk);
               #1;
               core_rv   = 1'b1;
               res_out_x = use_fixed ? fixed_res : r + 10'd3;
               @(posedge clk);
               #1;
               core_rv   = 1'b0;
               res_out_x = 10'h155;
            end
         end
      end
   end

   initial begin
      wr_t e;
      forever begin
         @(negedge clk);
         if (update_s) begin
            upd_cnt++;
            upd_q.push_back(cyc);
         end
         if (done) begin
            done_cnt++;
            check("busy_at_done", busy, 0);
         end
         if (core_rv) rv_cyc = cyc;
         if (we_res) begin
            check("wr_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("wr_addr", addr_res, e.a);
               check("wr_data", din_res, e.d);
               check("wr_after_rv", cyc - rv_cyc, 1);
            end
         end
      end
   end

   task automatic clr_stats();
      upd_cnt  = 0;
      done_cnt = 0;
      upd_q.delete();
   endtask

   task automatic start_pulse(input logic [AW-1:0] n,
                              input logic [FW-1:0] f,
                              output int s);
      @(negedge clk);
      num_rows = n;
      flgs_cfg = f;
      start    = 1'b1;
      s        = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int bound,
                            input int s, input int lat);
      bit seen = 0;
      int d = 0;
      for (int i = 0; i < bound && !seen; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1;
            d    = cyc;
         end
      end
      check({tag, "_done_seen"}, seen, 1);
      if (seen) check({tag, "_latency"}, d - s, lat);
   endtask

   task automatic chk_spacing(input string tag, input int sp);
      for (int i = 1; i < upd_q.size(); i++)
         check(tag, upd_q[i] - upd_q[i-1], sp);
   endtask

   initial begin
      int s;
      rst      = 1'b1;
      start    = 1'b0;
      spur_rv  = 1'b0;
      num_rows = '0;
      flgs_cfg = '0;
      for (int i = 0; i < 1024; i++) begin
         mem_lf[i] = '0;
         mem_sa[i] = '0;
         mem_rt[i] = '0;
      end
      mem_lf[0] = 144'h5229138a452291389c4e271389c5227148a4;
      mem_sa[0] = 144'h5627148a452291489c4e271389c4e27138a4;
      mem_rt[0] = 144'h52291489c52291489c4e271389c4e29138a4;
      for (int i = 1; i < 8; i++) begin
         mem_lf[i] = {$urandom, $urandom, $urandom, $urandom, $urandom};
         mem_sa[i] = {$urandom, $urandom, $urandom, $urandom, $urandom};
         mem_rt[i] = {$urandom, $urandom, $urandom, $urandom, $urandom};
      end
      repeat (3) @(negedge clk);
      check("rst_ctl", {busy, done, update_s, we_res, err, we_coef}, 0);
      check("rst_ops", {left_s_i ^ sam_s_i, row_ind, addr_coef}, 0);
      @(negedge clk);
      rst = 1'b0;

      // single row
      clr_stats();
      use_fixed = 1;
      fixed_res = 10'h1fe;
      sb.push_back('{a: 10'd0, d: 9'h1fe});
      start_pulse(1, 7, s);
      wait_done("single", 100, s, 9);
      check("single_lf", left_s_i, mem_lf[0]);
      check("single_sa", sam_s_i, mem_sa[0]);
      check("single_rt", right_s_i, mem_rt[0]);
      check("single_flgs", flgs_s_i, 7);
      check("single_upd", upd_cnt, 1);
      check("single_sb", sb.size(), 0);
      use_fixed = 0;

      // multi-row, immediate response
      clr_stats();
      for (int i = 0; i < 4; i++)
         sb.push_back('{a: AW'(i), d: RW'(i + 3)});
      start_pulse(4, 80'h1234, s);
      wait_done("multi", 200, s, 30);
      check("multi_upd", upd_cnt, 4);
      chk_spacing("multi_spacing", 7);
      check("multi_hold_lf", left_s_i, mem_lf[3]);
      check("multi_row_ind", row_ind, 3);
      check("multi_sb", sb.size(), 0);
      repeat (3) @(negedge clk);
      check("multi_done_cnt", done_cnt, 1);

      // zero rows
      clr_stats();
      start_pulse(0, 1, s);
      wait_done("zero", 20, s, 2);
      check("zero_upd", upd_cnt, 0);
      check("zero_we_coef", we_coef, 0);

      // start while busy is dropped
      clr_stats();
      for (int i = 0; i < 2; i++)
         sb.push_back('{a: AW'(i), d: RW'(i + 3)});
      start_pulse(2, 3, s);
      begin
         int s2;
         repeat (4) @(negedge clk);
         start_pulse(5, 9, s2);
      end
      wait_done("busy_start", 100, s, 16);
      repeat (20) @(negedge clk);
      check("busy_start_upd", upd_cnt, 2);
      check("busy_start_sb", sb.size(), 0);
      check("busy_start_idle", busy, 0);

      // back-pressure plus spurious res_valid in RD
      clr_stats();
      core_delay = 20;
      for (int i = 0; i < 2; i++)
         sb.push_back('{a: AW'(i), d: RW'(i + 3)});
      start_pulse(2, 5, s);
      spur_rv = 1'b1;
      @(negedge clk);
      spur_rv = 1'b0;
      wait_done("bp", 200, s, 54);
      check("bp_upd", upd_cnt, 2);
      chk_spacing("bp_spacing", 26);
      check("bp_sb", sb.size(), 0);
      core_delay = 1;

      // missing response for row 1
      clr_stats();
      skip_row = 1;
      sb.push_back('{a: 10'd0, d: 9'd3});
      sb.push_back('{a: 10'd2, d: 9'd5});
      start_pulse(3, 2, s);
`ifdef LIFT_SEQ_TIMEOUT_EN
      wait_done("tmo", 300, s, 85);
      check("tmo_err", err, 1);
      check("tmo_upd", upd_cnt, 3);
      check("tmo_sb", sb.size(), 0);
      skip_row = -1;
      clr_stats();
      sb.push_back('{a: 10'd0, d: 9'd3});
      start_pulse(1, 2, s);
      check("tmo_err_clr", err, 0);
      wait_done("tmo_after", 100, s, 9);
`else
      repeat (200) @(negedge clk);
      check("hang_busy", busy, 1);
      check("hang_err", err, 0);
      check("hang_sb", sb.size(), 1);
      skip_row = -1;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      sb.delete();
`endif

      // reset during WACK of row 2
      clr_stats();
      core_delay = 30;
      sb.push_back('{a: 10'd0, d: 9'd3});
      sb.push_back('{a: 10'd1, d: 9'd4});
      start_pulse(4, 1, s);
      for (int i = 0; i < 300 && upd_cnt < 3; i++) @(negedge clk);
      check("rst_mid_reach", upd_cnt, 3);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_ctl", {busy, update_s, we_res, err}, 0);
      rst = 1'b0;
      repeat (60) @(negedge clk);
      check("rst_mid_sb", sb.size(), 0);
      check("rst_mid_upd", upd_cnt, 3);
      check("rst_mid_done", done_cnt, 0);
      check("rst_mid_idle", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/lift_row_sequencer.md
Name: lift_row_sequencer

Overview:
- Controller that sequences the parallel lifting datapath (16 x 9-bit lanes per 144-bit word) over a block of rows.
- Per row: reads the left, sample and right coefficient RAMs at a shared address, loads the datapath operand registers, pulses update_s, waits for the datapath result, then writes it to the result RAM.
- Sits between the coefficient RAMs and the lifting core; replaces manual bench-driven address, write-enable and update sequencing.

Parameters:
- DW, 144, coefficient word width (16 lanes x 9 bits)
- AW, 10, RAM address width
- FW, 80, flag word width
- RW, 9, result RAM data width
- TMO, 64, max cycles to wait for res_valid before timeout (used only with the optional feature)

Ports:
- clk  in  1  system clock, all logic rising-edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to process rows 0..num_rows-1; ignored unless IDLE
- num_rows  in  AW  row count, sampled at accepted start
- flgs_cfg  in  FW  flag word, sampled at accepted start
- addr_coef  out  AW  shared read address to the lf/sa/rt RAMs
- we_coef  out  1  coefficient RAM write enable; constant 0 (sequencer never writes coefficients)
- dout_lf, dout_sa, dout_rt  in  DW  RAM read data, valid 1 cycle after address
- left_s_i, sam_s_i, right_s_i  out  DW  registered operands to the lifting core
- flgs_s_i  out  FW  registered flags to the lifting core
- row_ind  out  AW  current row index
- update_s  out  1  one-cycle strobe: operands valid, start lift
- res_valid  in  1  lifting core result strobe
- res_out_x  in  AW+0  core result; bits [RW-1:0] are written
- addr_res  out  AW  result RAM address
- din_res  out  RW  result RAM write data
- we_res  out  1  result RAM write enable
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse when the run completes
- err  out  1  sticky timeout flag

Behaviour:
- Reset: all outputs 0; state IDLE; err cleared. rst in any state returns to IDLE on the next edge; an in-flight write is dropped (we_res 0 that cycle).
- States: IDLE, RD, LAT, LOAD, FIRE, WACK, WR, NEXT, FIN.
- IDLE: on start, latch num_rows and flgs_cfg, row=0, clear err.
  - num_rows==0: go to FIN (done pulse, no RAM access).
  - Otherwise go to RD.
- RD: addr_coef=row → LAT (1-cycle RAM latency) → LOAD.
- LOAD: left_s_i/sam_s_i/right_s_i <= dout_lf/sa/rt; flgs_s_i <= latched flags; row_ind <= row → FIRE.
- FIRE: update_s=1 for exactly one cycle → WACK.
- WACK: wait for res_valid. On res_valid, capture res_out_x[RW-1:0] → WR. res_valid in any other state is ignored.
- WR: we_res=1 for one cycle, addr_res=row, din_res=captured value → NEXT.
- NEXT:
  - row==num_rows-1: go to FIN.
  - Otherwise row<=row+1 (AW-bit, no wrap since num_rows ≤ 2^AW-1) → RD.
- FIN: done=1 one cycle → IDLE. busy is low in the same cycle done is high.
- start while busy is ignored and not queued.
- Operand registers hold their last values after the run.
- Per-row latency with immediate res_valid (res_valid in the cycle after FIRE): 7 cycles, RD to NEXT inclusive.
- Minimum update_s spacing: 7 cycles.

Optional Feature:
- Macro LIFT_SEQ_TIMEOUT_EN.
- Defined: WACK counts cycles. If res_valid has not arrived after TMO cycles:
  - err set (sticky until next accepted start or rst);
  - write skipped;
  - go to NEXT, so the run continues.
- Undefined: WACK waits indefinitely; err is tied 0.

Test Plan:
- Reset mid-run: assert rst during WACK of row 2 → next cycle busy=0, update_s=0, we_res=0; no further writes.
- Single row: RAMs at addr 0 hold lf=144'h5229138a452291389c4e271389c5227148a4, sa=144'h5627148a452291489c4e271389c4e27138a4, rt=144'h52291489c52291489c4e271389c4e29138a4; num_rows=1, flgs_cfg=7; core returns res_out_x=10'h1fe one cycle after update_s → operands equal the RAM words, flgs_s_i=7, exactly one update_s pulse, one write of 9'h1fe at addr_res=0, then done.
- Multi-row: num_rows=4, core echoes row+3 → writes 3,4,5,6 at addresses 0..3 in order; update_s pulses 7 cycles apart; single done pulse.
- Edge cases: num_rows=0 → done 2 cycles after start, no update_s, no we_res. start pulsed while busy → ignored, row count unchanged.
- Back-pressure: res_valid delayed 20 cycles → update_s not re-issued; write occurs 1 cycle after res_valid; spurious res_valid during RD is ignored.
- With LIFT_SEQ_TIMEOUT_EN, TMO=64: suppress res_valid for row 1 of 3 → err=1, rows 0 and 2 written, address 1 untouched, done asserted. Without the macro, the same stimulus → busy stays 1.
